// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM block.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

  // Source of the word presented on rd_data for the last accepted read.
  typedef enum logic [1:0] {RD_SEL_ZERO, RD_SEL_ARRAY, RD_SEL_FWD} rd_sel_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int ram_addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_sdp_array.sv
// Storage core: one write port and one registered read port, no reset.
// Read-first ordering returns the old word on a same-address collision.
module ram_sdp_array #(
  parameter int N_BITS = 64,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [N_BITS-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [N_BITS-1:0] rdata
);

  logic [N_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_block_sdp.sv
// Simple-dual-port RAM with hardware clear sweep, read-valid strobe and selectable
// read-during-write policy. Define RAM_BLOCK_SDP_OUT_REG_EN for a 2-cycle read path.
module ram_block_sdp
  import ram_pkg::*;
#(
  parameter int N_BITS   = 64,
  parameter int SIZE_N   = 256,
  parameter int ADDR_W   = 20,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N_BITS-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [N_BITS-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam int AW = ram_addr_bits(SIZE_N);
  localparam logic [ADDR_W:0] SIZE_EXT = (ADDR_W + 1)'(SIZE_N);
  localparam logic [AW-1:0]   CNT_LAST = AW'(SIZE_N - 1);

  generate
    if (ADDR_W < 31 && SIZE_N > (1 << ADDR_W)) begin : g_size_chk
      $error("ram_block_sdp: SIZE_N does not fit in ADDR_W address bits");
    end
  endgenerate

  ram_state_t        state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic              busy_q;

  logic              ready, wr_acc, rd_acc, wr_oor, rd_oor, rdw_hit;
  logic              arr_we, arr_re;
  logic [AW-1:0]     arr_waddr;
  logic [N_BITS-1:0] arr_wdata, arr_rdata;

  rd_sel_t           sel_d, sel_p1_q;
  logic              vld_p1_q, err_p1_q;
  logic [N_BITS-1:0] fwd_data_p1_q, rd_data_p1;

  assign ready   = (state_q == RAM_READY);
  assign wr_acc  = ready && wr_en;
  assign rd_acc  = ready && rd_en;
  assign wr_oor  = ({1'b0, wr_addr} >= SIZE_EXT);
  assign rd_oor  = ({1'b0, rd_addr} >= SIZE_EXT);
  assign rdw_hit = wr_acc && !wr_oor && rd_acc && !rd_oor && (wr_addr == rd_addr);

  // A clear request always wins over the end-of-sweep transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RAM_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        RAM_CLEAR: begin
          if (clear) begin
            clr_cnt_q <= '0;
          end else if (clr_cnt_q == CNT_LAST) begin
            state_q   <= RAM_READY;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: begin
          if (clear) begin
            state_q   <= RAM_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;

  always_comb begin
    arr_we    = 1'b1;
    arr_waddr = clr_cnt_q;
    arr_wdata = '0;
    if (ready) begin
      arr_we    = wr_acc && !wr_oor;
      arr_waddr = wr_addr[AW-1:0];
      arr_wdata = wr_data;
    end
  end

  assign arr_re = rd_acc && !rd_oor;

  ram_sdp_array #(
    .N_BITS(N_BITS),
    .DEPTH (SIZE_N),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (arr_re),
    .raddr(rd_addr[AW-1:0]),
    .rdata(arr_rdata)
  );

  always_comb begin
    sel_d = sel_p1_q;
    if (rd_acc) begin
      if (rd_oor)                                sel_d = RD_SEL_ZERO;
      else if (RDW_MODE == RDW_NEW && rdw_hit)   sel_d = RD_SEL_FWD;
      else                                       sel_d = RD_SEL_ARRAY;
    end
  end

  // ---- stage p1: array read issued, selection and status registered ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1_q <= RD_SEL_ZERO;
      vld_p1_q <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      sel_p1_q <= sel_d;
      vld_p1_q <= rd_acc;
      err_p1_q <= (wr_acc && wr_oor) || (rd_acc && rd_oor);
    end
  end

  always_ff @(posedge clk) begin
    if (rdw_hit) fwd_data_p1_q <= wr_data;
  end

  always_comb begin
    rd_data_p1 = '0;
    case (sel_p1_q)
      RD_SEL_ARRAY: rd_data_p1 = arr_rdata;
      RD_SEL_FWD:   rd_data_p1 = fwd_data_p1_q;
      default:      rd_data_p1 = '0;
    endcase
  end

`ifdef RAM_BLOCK_SDP_OUT_REG_EN
  logic [N_BITS-1:0] rd_data_p2_q;
  logic              vld_p2_q, err_p2_q;

  // ---- stage p2: output register, not flushed by a clear request ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p2_q <= '0;
      vld_p2_q     <= 1'b0;
      err_p2_q     <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      err_p2_q <= err_p1_q;
      if (vld_p1_q) rd_data_p2_q <= rd_data_p1;
    end
  end

  assign rd_data  = rd_data_p2_q;
  assign rd_valid = vld_p2_q;
  assign addr_err = err_p2_q;
`else
  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1_q;
  assign addr_err = err_p1_q;
`endif

endmodule

// File: doc/ram_block_sdp.md
Name: ram_block_sdp

Overview:
Parametrised simple-dual-port RAM. It is the next generation of the single-port data RAM used for the matrix and sample buffers in the fetal ECG datapath. It has one write port and one read port usable in the same cycle, a read-valid strobe, and a selectable read-during-write policy. After reset or on request, a hardware clear sweep zeroes every word. It sits between the sample/matrix producers and the arithmetic cores, which consume `rd_data` on `rd_valid`.

Parameters:
- N_BITS, 64, data word width in bits (≥1).
- SIZE_N, 256, number of words (≥2).
- ADDR_W, 20, address port width; SIZE_N ≤ 2**ADDR_W required, checked by elaboration assertion.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (written) data.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  single-cycle request to zero the whole array.
- busy  out  1  high while clear sweep is running; both ports are ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  N_BITS  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  N_BITS  read data, valid when rd_valid.
- rd_valid  out  1  one pulse per accepted read, aligned with rd_data.
- addr_err  out  1  one-cycle pulse when an accepted access uses an address ≥ SIZE_N.

Behaviour:
- Reset (rst_n low, async): state = CLEAR, clear counter = 0, busy = 1, rd_data = 0, rd_valid = 0, addr_err = 0. Array contents are not reset directly; the sweep zeroes them.
- FSM states are CLEAR and READY.
- CLEAR state:
  - Each cycle writes 0 to address clr_cnt, then clr_cnt++.
  - On the cycle clr_cnt == SIZE_N-1 is written, the FSM moves to READY; busy falls the next cycle.
  - Sweep length is exactly SIZE_N cycles after rst_n rises.
  - wr_en and rd_en are ignored: no write, rd_valid stays 0, no addr_err.
  - clear asserted during CLEAR restarts clr_cnt at 0.
  - Reset mid-sweep restarts from 0.
- READY state:
  - clear = 1 enters CLEAR next cycle with clr_cnt = 0.
  - A same-cycle wr_en/rd_en alongside clear is still serviced normally.
- Write: when wr_en and wr_addr < SIZE_N, the word is stored at the clock edge. When wr_addr ≥ SIZE_N, the write is dropped and addr_err pulses next cycle.
- Read latency is 1 cycle (2 with the optional feature). rd_en in cycle T gives rd_valid = 1 and rd_data in cycle T+1.
  - Back-to-back reads give one result per cycle.
  - With no read, rd_valid = 0 and rd_data holds its last value.
- Out-of-range read returns rd_data = 0 with rd_valid = 1, and addr_err pulses in the same cycle as rd_valid.
- Simultaneous read and write to the same in-range address:
  - RDW_MODE = 0 returns the previous contents.
  - RDW_MODE = 1 returns wr_data (forwarded, no extra latency).
  - Different addresses never interact.
- addr_err pulses if either port errs (OR of both).

Optional Feature:
- Macro RAM_BLOCK_SDP_OUT_REG_EN.
- Defined: an extra output register stage is added after the array read for timing. Read latency becomes 2 and rd_valid/addr_err are delayed identically. The stage resets to 0, and a clear entry does not flush reads already in flight.
- Undefined: latency 1 as above.
- RDW semantics are judged at the cycle the read is accepted in both builds.

Decomposition:
- Package ram_pkg:
  - typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t.
  - localparams RDW_OLD = 0, RDW_NEW = 1.
  - function clog2-based ADDR sizing helper.
- Sub-module ram_sdp_array: pure storage with one write port and one registered read port, no reset, inferable as block RAM. The top module holds the FSM, clear counter, write mux (sweep vs user), bounds checks, RDW forwarding and valid pipeline.

Test Plan:
- Reset release with SIZE_N = 16 -> busy = 1 for exactly 16 cycles. Reads at 0..15 afterwards all return 0 with rd_valid one cycle after each rd_en.
- Write 0x0123_4567_89AB_CDEF to address 5, read 5 next cycle -> rd_data = 0x0123456789ABCDEF at T+1.
- Same-cycle write 0xAAAA to address 3 (holding 0x5555) and read of 3:
  - RDW_MODE = 0 -> 0x5555.
  - RDW_MODE = 1 -> 0xAAAA.
  - A read the following cycle returns 0xAAAA in both modes.
- Write to address 20 and read address 17 with SIZE_N = 16:
  - Write dropped, addr_err pulses.
  - Read gives rd_data = 0, rd_valid = 1, addr_err = 1.
  - Re-reading 4 (= 20 mod 16) returns unchanged data.
- Assert clear in READY, pulse clear again 5 cycles into the sweep, and drive rd_en throughout:
  - busy stays high 5+16 cycles.
  - No rd_valid while busy.
  - All words read 0 afterwards.
- Drop rst_n mid-sweep and mid-read burst -> outputs go to reset values immediately and the sweep restarts from 0. With RAM_BLOCK_SDP_OUT_REG_EN, repeat the write/read test and check latency 2.
